// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, cop0 register
// addresses that count as exception-related writes, and the load-use
// hazard equation.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2,
    COP0_DRAIN = 2'd3
  } hazard_state_t;

  // cop0 RD/SEL pairs whose writes must drain the pipeline
  localparam logic [4:0] CP0_RD_STATUS    = 5'd12;
  localparam logic [2:0] CP0_SEL_STATUS   = 3'd0;
  localparam logic [4:0] CP0_RD_EPC       = 5'd14;
  localparam logic [2:0] CP0_SEL_EPC      = 3'd0;
  localparam logic [4:0] CP0_RD_EBASE     = 5'd15;
  localparam logic [2:0] CP0_SEL_EBASE    = 3'd1;
  localparam logic [4:0] CP0_RD_ERROREPC  = 5'd30;
  localparam logic [2:0] CP0_SEL_ERROREPC = 3'd0;

  // Used by the execute stage to derive exe_cop0_exc_write from an mtc0
  function automatic logic is_cop0_exc_reg(input logic [4:0] rd, input logic [2:0] sel);
    return (rd == CP0_RD_STATUS   && sel == CP0_SEL_STATUS)   ||
           (rd == CP0_RD_EPC      && sel == CP0_SEL_EPC)      ||
           (rd == CP0_RD_EBASE    && sel == CP0_SEL_EBASE)    ||
           (rd == CP0_RD_ERROREPC && sel == CP0_SEL_ERROREPC);
  endfunction

  // $0 is never a real dependency, so a load targeting it cannot hazard
  function automatic logic load_use_hazard(input logic       exe_load,
                                           input logic [4:0] exe_dest,
                                           input logic       uses_rs,
                                           input logic [4:0] rs,
                                           input logic       uses_rt,
                                           input logic [4:0] rt);
    return exe_load && (exe_dest != 5'd0) &&
           ((uses_rs && rs == exe_dest) || (uses_rt && rt == exe_dest));
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode/execute hazard inputs and pipeline stall controls.
// slave: the hazard controller; master: the pipeline side.
interface hazard_controller_if;

  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic       dec_uses_rs;
  logic       dec_uses_rt;
  logic       dec_reads_hilo;
  logic       dec_mdu_start;
  logic       exe_load;
  logic [4:0] exe_dest_reg;
  logic       exe_cop0_exc_write;
  logic       stall_fetch;
  logic       stall_decode;
  logic       flush_execute;
  logic       mdu_busy;
  logic [1:0] state_o;

  modport slave (
    input  dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_reads_hilo, dec_mdu_start,
    input  exe_load, exe_dest_reg, exe_cop0_exc_write,
    output stall_fetch, stall_decode, flush_execute, mdu_busy, state_o
  );

  modport master (
    output dec_rs, dec_rt, dec_uses_rs, dec_uses_rt, dec_reads_hilo, dec_mdu_start,
    output exe_load, exe_dest_reg, exe_cop0_exc_write,
    input  stall_fetch, stall_decode, flush_execute, mdu_busy, state_o
  );

endinterface

// File: rtl/hazard_controller_stall_counter.sv
// Loadable down-counter that saturates at zero. `last` flags a count of
// one so the owner can leave its wait state on the same edge the count
// reaches zero.
module stall_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: load wins over decrement, never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
  assign last = (count_q == WIDTH'(1));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, multiply/divide hi/lo
// interlock and pipeline drain after exception-related cop0 writes.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | no hazard in progress; evaluate decode/execute each cycle
//   LOAD_STALL | bubble already inserted; forwarder supplies load data
//   MDU_WAIT   | multiply/divide owns hi/lo; block hi/lo readers and MDU ops
//   COP0_DRAIN | stall and flush while the cop0 write takes effect
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MDU_CYCLES        = 32,
  parameter int COP0_DRAIN_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  localparam logic [5:0] MDU_LOAD  = 6'(MDU_CYCLES - 1);
  localparam logic [2:0] COP0_LOAD = 3'(COP0_DRAIN_CYCLES);

  hazard_state_t state_q;
  hazard_state_t state_d;

  logic load_use;
  logic stall;
  logic flush;
  logic busy;
  logic mdu_load;
  logic mdu_dec;
  logic mdu_zero;
  logic mdu_last;
  logic cop_load;
  logic cop_dec;
  logic cop_zero;
  logic cop_last;

  assign load_use = load_use_hazard(hz.exe_load, hz.exe_dest_reg,
                                    hz.dec_uses_rs, hz.dec_rs,
                                    hz.dec_uses_rt, hz.dec_rt);

  stall_counter #(.WIDTH(6)) u_mdu_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mdu_load),
    .load_val (MDU_LOAD),
    .dec      (mdu_dec),
    .zero     (mdu_zero),
    .last     (mdu_last)
  );

  stall_counter #(.WIDTH(3)) u_cop0_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cop_load),
    .load_val (COP0_LOAD),
    .dec      (cop_dec),
    .zero     (cop_zero),
    .last     (cop_last)
  );

  // next-state and stall outputs; reset forces everything quiet
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    flush    = 1'b0;
    busy     = 1'b0;
    mdu_load = 1'b0;
    mdu_dec  = 1'b0;
    cop_load = 1'b0;
    cop_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // decode is held during any stall, so lower-priority events
        // present now come back around once we return here
        if (load_use) begin
          stall   = 1'b1;
          flush   = 1'b1;
          state_d = LOAD_STALL;
        end else if (hz.exe_cop0_exc_write) begin
          cop_load = 1'b1;
          state_d  = COP0_DRAIN;
        end else if (hz.dec_mdu_start) begin
          mdu_load = 1'b1;
          state_d  = MDU_WAIT;
        end
      end
      LOAD_STALL: begin
        state_d = IDLE;
      end
      MDU_WAIT: begin
        busy    = !mdu_zero;
        mdu_dec = 1'b1;
        // a load-use bubble here does not pause the MDU countdown
        if (load_use || hz.dec_reads_hilo || hz.dec_mdu_start) begin
          stall = 1'b1;
          flush = 1'b1;
        end
        if (mdu_last || mdu_zero) begin
          state_d = IDLE;
        end
      end
      COP0_DRAIN: begin
        stall   = 1'b1;
        flush   = 1'b1;
        cop_dec = 1'b1;
        if (cop_last || cop_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d  = IDLE;
      stall    = 1'b0;
      flush    = 1'b0;
      busy     = 1'b0;
      mdu_load = 1'b0;
      mdu_dec  = 1'b0;
      cop_load = 1'b0;
      cop_dec  = 1'b0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign hz.stall_fetch   = stall;
  assign hz.stall_decode  = stall;
  assign hz.flush_execute = flush;
  assign hz.mdu_busy      = busy;
  assign hz.state_o       = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed IDLE vector table,
// multi-cycle corner sequences and a randomized run against a cycle model.
module tb_hazard_controller;

  localparam int MDU_CYCLES        = 32;
  localparam int COP0_DRAIN_CYCLES = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_controller_if hz ();

  hazard_controller #(
    .MDU_CYCLES        (MDU_CYCLES),
    .COP0_DRAIN_CYCLES (COP0_DRAIN_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: mode 0 idle, 1 one-cycle load bubble done,
  // 2 mdu owns hi/lo, 3 cop0 drain; m_left = cycles still to spend in mode
  int   m_st   = 0;
  int   m_left = 0;
  int   n_st;
  int   n_left;
  logic e_stall;
  logic e_flush;
  logic e_busy;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       hilo;
    logic       start;
    logic       load;
    logic [4:0] dest;
    logic       cop0;
    logic       exp_stall;
    logic [1:0] exp_next;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    hz.dec_rs             = '0;
    hz.dec_rt             = '0;
    hz.dec_uses_rs        = 1'b0;
    hz.dec_uses_rt        = 1'b0;
    hz.dec_reads_hilo     = 1'b0;
    hz.dec_mdu_start      = 1'b0;
    hz.exe_load           = 1'b0;
    hz.exe_dest_reg       = '0;
    hz.exe_cop0_exc_write = 1'b0;
  endtask

  task automatic model_eval();
    bit dep;
    bit lu;
    dep = (hz.dec_uses_rs && hz.dec_rs == hz.exe_dest_reg) ||
          (hz.dec_uses_rt && hz.dec_rt == hz.exe_dest_reg);
    lu  = hz.exe_load && hz.exe_dest_reg != 0 && dep;
    e_stall = 1'b0;
    e_flush = 1'b0;
    e_busy  = 1'b0;
    n_st    = m_st;
    n_left  = m_left;
    if (reset) begin
      n_st   = 0;
      n_left = 0;
    end else if (m_st == 0) begin
      if (lu) begin
        e_stall = 1'b1;
        e_flush = 1'b1;
        n_st    = 1;
      end else if (hz.exe_cop0_exc_write) begin
        n_st   = 3;
        n_left = COP0_DRAIN_CYCLES;
      end else if (hz.dec_mdu_start) begin
        n_st   = 2;
        n_left = MDU_CYCLES - 1;
      end
    end else if (m_st == 1) begin
      n_st = 0;
    end else if (m_st == 2) begin
      e_busy = 1'b1;
      if (lu || hz.dec_reads_hilo || hz.dec_mdu_start) begin
        e_stall = 1'b1;
        e_flush = 1'b1;
      end
      n_left = m_left - 1;
      if (n_left == 0) n_st = 0;
    end else begin
      e_stall = 1'b1;
      e_flush = 1'b1;
      n_left  = m_left - 1;
      if (n_left == 0) n_st = 0;
    end
  endtask

  // called just after a negedge with inputs applied; ends at the next negedge
  task automatic step(input string nm);
    logic [1:0] st2;
    #1;
    model_eval();
    st2 = m_st[1:0];
    check(nm, 32'({hz.stall_fetch, hz.stall_decode, hz.flush_execute, hz.mdu_busy, hz.state_o}),
              32'({e_stall, e_stall, e_flush, e_busy, st2}));
    @(posedge clk);
    m_st   = n_st;
    m_left = n_left;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step("reset");
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ns;
    int nf;
    int i;

    //           rs  rt  urs urt hilo st  ld  dest cop0 stall next
    vecs[0]  = '{5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 0, 1, 2'd1};
    vecs[1]  = '{5'd0, 5'd0, 1, 0, 0, 0, 1, 5'd0, 0, 0, 2'd0};
    vecs[2]  = '{5'd1, 5'd7, 0, 1, 0, 0, 1, 5'd7, 0, 1, 2'd1};
    vecs[3]  = '{5'd9, 5'd0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 2'd0};
    vecs[4]  = '{5'd3, 5'd0, 1, 0, 0, 0, 0, 5'd3, 0, 0, 2'd0};
    vecs[5]  = '{5'd4, 5'd6, 1, 1, 0, 0, 1, 5'd5, 0, 0, 2'd0};
    vecs[6]  = '{5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 1, 0, 2'd3};
    vecs[7]  = '{5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 0, 0, 2'd2};
    vecs[8]  = '{5'd5, 5'd0, 1, 0, 0, 0, 1, 5'd5, 1, 1, 2'd1};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 0, 1, 0, 5'd0, 1, 0, 2'd3};
    vecs[10] = '{5'd2, 5'd0, 1, 0, 0, 1, 1, 5'd2, 0, 1, 2'd1};
    vecs[11] = '{5'd0, 5'd0, 0, 0, 1, 0, 0, 5'd0, 0, 0, 2'd0};

    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    m_st   = 0;
    m_left = 0;

    // reset state with reset still asserted
    step("reset_state");
    reset = 1'b0;

    // IDLE decision table
    foreach (vecs[k]) begin
      do_reset();
      hz.dec_rs             = vecs[k].rs;
      hz.dec_rt             = vecs[k].rt;
      hz.dec_uses_rs        = vecs[k].urs;
      hz.dec_uses_rt        = vecs[k].urt;
      hz.dec_reads_hilo     = vecs[k].hilo;
      hz.dec_mdu_start      = vecs[k].start;
      hz.exe_load           = vecs[k].load;
      hz.exe_dest_reg       = vecs[k].dest;
      hz.exe_cop0_exc_write = vecs[k].cop0;
      #1;
      model_eval();
      check($sformatf("vec%0d_stall", k),
            32'({hz.stall_fetch, hz.stall_decode, hz.flush_execute}),
            32'({3{vecs[k].exp_stall}}));
      @(posedge clk);
      m_st   = n_st;
      m_left = n_left;
      @(negedge clk);
      check($sformatf("vec%0d_next", k), 32'(hz.state_o), 32'(vecs[k].exp_next));
      clear_inputs();
    end

    // load-use plus cop0 write: bubble first, cop0 write not latched
    do_reset();
    hz.dec_rs = 5'd5; hz.dec_uses_rs = 1'b1; hz.exe_load = 1'b1;
    hz.exe_dest_reg = 5'd5; hz.exe_cop0_exc_write = 1'b1;
    step("lu_cop0_a");
    check("lu_cop0_in_ls", 32'(hz.state_o), 32'd1);
    clear_inputs();
    step("lu_cop0_b");
    check("lu_cop0_back_idle", 32'(hz.state_o), 32'd0);
    step("lu_cop0_c");
    check("lu_cop0_stays_idle", 32'(hz.state_o), 32'd0);

    // mdu start, then mfhi held in decode until hi/lo is free
    do_reset();
    hz.dec_mdu_start = 1'b1;
    step("mdu_start");
    hz.dec_mdu_start  = 1'b0;
    hz.dec_reads_hilo = 1'b1;
    nb = 0;
    ns = 0;
    i  = 0;
    while (hz.state_o != 2'd0 && i < 60) begin
      if (hz.mdu_busy) nb++;
      if (hz.stall_decode && hz.stall_fetch && hz.flush_execute) ns++;
      step("mdu_wait");
      i++;
    end
    check("mdu_busy_cycles", 32'(nb), 32'(MDU_CYCLES - 1));
    check("mfhi_stall_cycles", 32'(ns), 32'(MDU_CYCLES - 1));
    check("mfhi_released", 32'({hz.stall_decode, hz.mdu_busy, hz.state_o}), 32'd0);
    clear_inputs();

    // cop0 drain length
    do_reset();
    hz.exe_cop0_exc_write = 1'b1;
    step("cop0_write");
    hz.exe_cop0_exc_write = 1'b0;
    ns = 0;
    nf = 0;
    i  = 0;
    while (hz.state_o != 2'd0 && i < 20) begin
      if (hz.stall_decode && hz.stall_fetch) ns++;
      if (hz.flush_execute) nf++;
      step("cop0_drain");
      i++;
    end
    check("cop0_stall_cycles", 32'(ns), 32'(COP0_DRAIN_CYCLES));
    check("cop0_flush_cycles", 32'(nf), 32'(COP0_DRAIN_CYCLES));
    check("cop0_after", 32'({hz.stall_decode, hz.flush_execute}), 32'd0);

    // reset in the middle of an mdu operation (counter at 10)
    do_reset();
    hz.dec_mdu_start = 1'b1;
    step("mdu_start2");
    hz.dec_mdu_start  = 1'b0;
    hz.dec_reads_hilo = 1'b1;
    for (int c = 0; c < MDU_CYCLES - 1 - 10; c++) step("mdu_run");
    check("mdu_mid_state", 32'(hz.state_o), 32'd2);
    reset = 1'b1;
    #1;
    check("mdu_rst_outputs",
          32'({hz.stall_fetch, hz.stall_decode, hz.flush_execute, hz.mdu_busy}), 32'd0);
    step("mdu_rst_edge");
    reset = 1'b0;
    #1;
    check("mdu_rst_after",
          32'({hz.stall_fetch, hz.stall_decode, hz.flush_execute, hz.mdu_busy, hz.state_o}),
          32'd0);
    clear_inputs();

    // same for cop0 drain
    do_reset();
    hz.exe_cop0_exc_write = 1'b1;
    step("cop0_write2");
    reset = 1'b1;
    #1;
    check("cop0_rst_outputs",
          32'({hz.stall_fetch, hz.stall_decode, hz.flush_execute, hz.mdu_busy}), 32'd0);
    step("cop0_rst_edge");
    reset = 1'b0;
    clear_inputs();

    // randomized traffic against the model
    for (int r = 0; r < 3000; r++) begin
      reset                 = ($urandom_range(0, 149) == 0);
      hz.dec_rs             = 5'($urandom_range(0, 3));
      hz.dec_rt             = 5'($urandom_range(0, 3));
      hz.dec_uses_rs        = 1'($urandom_range(0, 1));
      hz.dec_uses_rt        = 1'($urandom_range(0, 1));
      hz.dec_reads_hilo     = ($urandom_range(0, 3) == 0);
      hz.dec_mdu_start      = ($urandom_range(0, 7) == 0);
      hz.exe_load           = ($urandom_range(0, 3) == 0);
      hz.exe_dest_reg       = 5'($urandom_range(0, 3));
      hz.exe_cop0_exc_write = ($urandom_range(0, 15) == 0);
      step("random");
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 32: execute-stage cycles a multiply/divide occupies hi/lo (legal range 2..63).
REQ-002 SHALL have parameter COP0_DRAIN_CYCLES, default 2: bubbles inserted after a write to an exception-related cop0 register (legal range 1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 dec_rs, dec_rt  input  5 each  source GPR indices of the decode-stage instruction.
REQ-006 dec_uses_rs, dec_uses_rt  input  1 each  decode instruction actually reads rs / rt.
REQ-007 dec_reads_hilo  input  1  decode instruction reads hi or lo (mfhi/mflo, madd-class).
REQ-008 dec_mdu_start  input  1  decode instruction is a multiply/divide.
REQ-009 exe_load  input  1  execute-stage instruction is a memory load.
REQ-010 exe_dest_reg  input  5  execute-stage destination GPR.
REQ-011 exe_cop0_exc_write  input  1  execute-stage instruction writes EPC, ErrorEPC, Status or EBase.
REQ-012 stall_fetch, stall_decode  output  1 each  hold the fetch/decode pipeline registers.
REQ-013 flush_execute  output  1  load a bubble into the execute pipeline register.
REQ-014 mdu_busy  output  1  multiply/divide in flight.
REQ-015 state_o  output  2  current FSM state, for debug and verification.

Function
REQ-016 FSM states SHALL be IDLE=0, LOAD_STALL=1, MDU_WAIT=2, COP0_DRAIN=3.
REQ-017 A load-use hazard SHALL be exe_load & exe_dest_reg!=0 & ((dec_uses_rs & dec_rs==exe_dest_reg) | (dec_uses_rt & dec_rt==exe_dest_reg)).
REQ-018 In IDLE, a load-use hazard SHALL assert stall_fetch, stall_decode and flush_execute combinationally in the same cycle and move to LOAD_STALL.
REQ-019 LOAD_STALL SHALL last exactly one cycle with all three outputs low, then return to IDLE; the forwarder supplies the loaded value from the memory stage.
REQ-020 In IDLE with no load-use hazard, dec_mdu_start SHALL load a 6-bit counter with MDU_CYCLES-1, assert mdu_busy from the next cycle, and move to MDU_WAIT.
REQ-021 In MDU_WAIT the counter SHALL decrement every cycle; mdu_busy SHALL be high while the counter is nonzero; at zero the FSM SHALL return to IDLE and mdu_busy SHALL drop.
REQ-022 In MDU_WAIT, dec_reads_hilo or dec_mdu_start SHALL assert stall_fetch, stall_decode and flush_execute every cycle until IDLE; other instructions SHALL flow unstalled.
REQ-023 In IDLE, exe_cop0_exc_write SHALL load a 3-bit counter with COP0_DRAIN_CYCLES and move to COP0_DRAIN.
REQ-024 COP0_DRAIN SHALL assert stall_fetch and stall_decode for exactly COP0_DRAIN_CYCLES cycles, with flush_execute high in each of those cycles, then return to IDLE.
REQ-025 Priority in IDLE SHALL be: load-use > cop0 drain > MDU start; a lower-priority event seen in the same cycle SHALL be re-evaluated after the stall, because the decode instruction is held.
REQ-026 Events arriving in LOAD_STALL or COP0_DRAIN SHALL be ignored; a held instruction is re-evaluated on return to IDLE.
REQ-027 A load-use hazard in MDU_WAIT SHALL stall for one cycle, as in REQ-018, without leaving MDU_WAIT or pausing the counter.
REQ-028 stall_fetch SHALL always equal stall_decode; flush_execute SHALL never be high while stall_decode is low.

Reset
REQ-029 While reset is high at a clock edge, the FSM SHALL go to IDLE, both counters SHALL clear to 0, and state_o SHALL read 0.
REQ-030 While reset is asserted, stall_fetch, stall_decode, flush_execute and mdu_busy SHALL be 0, including when reset is asserted in the middle of MDU_WAIT or COP0_DRAIN.

Structure
REQ-031 The state enum hazard_state_t and the cop0 RD/SEL constants used to derive exe_cop0_exc_write SHALL live in the shared pipeline package; MDU_CYCLES SHALL be a module parameter.
REQ-032 The down-counter SHALL be one sub-module, stall_counter (load, decrement, zero flag), instantiated twice with widths 6 and 3.

Verification
REQ-033 Load-use: exe_load=1, exe_dest_reg=5, dec_rs=5, dec_uses_rs=1 -> stalls and flush high for 1 cycle, state 0->1->0.
REQ-034 Register $0: as REQ-033 but exe_dest_reg=0 and dec_rs=0 -> no stall.
REQ-035 MDU: dec_mdu_start pulse, then mfhi in decode on the next cycle -> mdu_busy high for 31 cycles, mfhi stalled until state returns to 0.
REQ-036 Cop0: exe_cop0_exc_write=1 with COP0_DRAIN_CYCLES=2 -> stalls and flush high for exactly 2 cycles.
REQ-037 Simultaneous events: load-use and exe_cop0_exc_write in the same cycle -> LOAD_STALL taken first, cop0 write not latched.
REQ-038 Reset mid-MDU: reset asserted at MDU counter=10 -> next cycle state 0, mdu_busy 0, no stall.
